// File: rtl/pattern_count_engine.sv
// Start/ack responder: reads a 5-bit pattern and a message from data memory, counts matches, writes results back.
// Optional define PATTERN_CROSS_COUNT_EN adds the stream-wide (byte-crossing) window count and its result write.
module pattern_count_engine #(
    parameter int PAT_ADDR = 32,
    parameter int MSG_LEN  = 32,
    parameter int RES_ADDR = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wen,
    output logic [7:0] mem_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        PAT,
        SCAN,
        DRAIN,
        WR_B,
        WR_O,
`ifdef PATTERN_CROSS_COUNT_EN
        WR_S,
`endif
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] idx_reg, idx_next;
    logic [4:0] pat_reg;
    logic [7:0] ctb_reg;
    logic [7:0] cto_reg;
    logic       ack_reg;
    logic [3:0] win_hit;
    logic [7:0] ctb_inc;
    logic       byte_valid;
    logic       start_run;

    // Bytes arrive one cycle after their address; SCAN with idx 0 carries the pattern byte instead.
    assign byte_valid = ((state_reg == SCAN) && (idx_reg != 8'd0)) || (state_reg == DRAIN);
    assign start_run  = (state_reg == IDLE) && start;
    assign ack        = ack_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_in_byte
            assign win_hit[gi] = (mem_rdata[gi+4:gi] == pat_reg);
        end
    endgenerate

    assign ctb_inc = 8'($countones(win_hit));

`ifdef PATTERN_CROSS_COUNT_EN
    logic [7:0]  cts_reg;
    logic [3:0]  carry_reg;
    logic        first_reg;
    logic [11:0] stream_win;
    logic [7:0]  cross_hit;
    logic [7:0]  cross_mask;
    logic [7:0]  cts_inc;

    // Stream order is MSB first, so the previous byte's low nibble precedes this byte.
    assign stream_win = {carry_reg, mem_rdata};
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cross
            assign cross_hit[gi] = (stream_win[gi+4:gi] == pat_reg);
        end
    endgenerate

    assign cross_mask = first_reg ? 8'h0F : 8'hFF;
    assign cts_inc    = 8'($countones(cross_hit & cross_mask));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= 8'd0;
            pat_reg   <= 5'd0;
            ctb_reg   <= 8'd0;
            cto_reg   <= 8'd0;
            ack_reg   <= 1'b0;
`ifdef PATTERN_CROSS_COUNT_EN
            cts_reg   <= 8'd0;
            carry_reg <= 4'd0;
            first_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (start_run) begin
                ack_reg   <= 1'b0;
                ctb_reg   <= 8'd0;
                cto_reg   <= 8'd0;
`ifdef PATTERN_CROSS_COUNT_EN
                cts_reg   <= 8'd0;
                carry_reg <= 4'd0;
                first_reg <= 1'b1;
`endif
            end
            if (state_reg == DONE) begin
                ack_reg <= 1'b1;
            end
            if ((state_reg == SCAN) && (idx_reg == 8'd0)) begin
                pat_reg <= mem_rdata[7:3];
            end
            if (byte_valid) begin
                ctb_reg <= ctb_reg + ctb_inc;
                cto_reg <= cto_reg + 8'(|win_hit);
`ifdef PATTERN_CROSS_COUNT_EN
                cts_reg   <= cts_reg + cts_inc;
                carry_reg <= mem_rdata[3:0];
                first_reg <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mem_addr   = 8'd0;
        mem_wen    = 1'b0;
        mem_wdata  = 8'd0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = PAT;
                end
            end
            PAT: begin
                mem_addr   = 8'(PAT_ADDR);
                idx_next   = 8'd0;
                state_next = SCAN;
            end
            SCAN: begin
                mem_addr = idx_reg;
                idx_next = idx_reg + 8'd1;
                if (idx_reg == 8'(MSG_LEN - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = WR_B;
            end
            WR_B: begin
                mem_wen    = 1'b1;
                mem_addr   = 8'(RES_ADDR);
                mem_wdata  = ctb_reg;
                state_next = WR_O;
            end
            WR_O: begin
                mem_wen   = 1'b1;
                mem_addr  = 8'(RES_ADDR + 1);
                mem_wdata = cto_reg;
`ifdef PATTERN_CROSS_COUNT_EN
                state_next = WR_S;
`else
                state_next = DONE;
`endif
            end
`ifdef PATTERN_CROSS_COUNT_EN
            WR_S: begin
                mem_wen    = 1'b1;
                mem_addr   = 8'(RES_ADDR + 2);
                mem_wdata  = cts_reg;
                state_next = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Randomized bench for pattern_count_engine with a bit-stream reference model and a small memory model.
module tb_pattern_count_engine;

    localparam int PAT_ADDR = 32;
    localparam int MSG_LEN  = 32;
    localparam int RES_ADDR = 33;
`ifdef PATTERN_CROSS_COUNT_EN
    localparam int LAT = 38;
    localparam int NWR = 3;
`else
    localparam int LAT = 37;
    localparam int NWR = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [7:0] mem_wdata;

    logic [7:0] msg [MSG_LEN];
    logic [7:0] pat_byte;
    logic [7:0] res [3];
    int         wr_count;
    logic       clr = 1'b0;

    int checks = 0;
    int errors = 0;

    pattern_count_engine #(
        .PAT_ADDR(PAT_ADDR),
        .MSG_LEN (MSG_LEN),
        .RES_ADDR(RES_ADDR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ack      (ack),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_wen  (mem_wen),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_addr == 8'(PAT_ADDR)) mem_rdata <= pat_byte;
        else if (mem_addr < 8'(MSG_LEN)) mem_rdata <= msg[mem_addr[4:0]];
        else mem_rdata <= 8'h00;
        if (clr) begin
            res[0]   <= 8'hEE;
            res[1]   <= 8'hEE;
            res[2]   <= 8'hEE;
            wr_count <= 0;
        end else if (mem_wen) begin
            wr_count <= wr_count + 1;
            if (mem_addr >= 8'(RES_ADDR) && mem_addr < 8'(RES_ADDR + 3))
                res[2'(mem_addr - 8'(RES_ADDR))] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_ctb();
        int n = 0;
        for (int k = 0; k < MSG_LEN; k++)
            for (int s = 0; s < 4; s++)
                if (((int'(msg[k]) >> s) & 31) == int'(pat_byte[7:3])) n++;
        return n;
    endfunction

    function automatic int ref_cto();
        int n = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            bit any = 0;
            for (int s = 0; s < 4; s++)
                if (((int'(msg[k]) >> s) & 31) == int'(pat_byte[7:3])) any = 1;
            if (any) n++;
        end
        return n;
    endfunction

    function automatic int ref_cts();
        bit stream [MSG_LEN*8];
        int n = 0;
        for (int k = 0; k < MSG_LEN; k++)
            for (int m = 0; m < 8; m++)
                stream[8*k+m] = msg[k][7-m];
        for (int i = 0; i + 5 <= MSG_LEN*8; i++) begin
            int v = 0;
            for (int j = 0; j < 5; j++) v = v * 2 + int'(stream[i+j]);
            if (v == int'(pat_byte[7:3])) n++;
        end
        return n;
    endfunction

    task automatic clear_results();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int k = 0; k < MSG_LEN; k++) msg[k] = v;
    endtask

    task automatic run(input string name, input bit mid_start);
        int cyc = 0;
        int ack_cycle = -1;
        clear_results();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) check({name, "_ack_clear"}, int'(ack), 0);
            if (ack) begin
                ack_cycle = cyc;
                break;
            end
            start = mid_start && (cyc == 9);
        end
        start = 1'b0;
        check({name, "_latency"}, ack_cycle, LAT);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_ack_hold"}, int'(ack), 1);
        check({name, "_writes"}, wr_count, NWR);
        check({name, "_ctb"}, int'(res[0]), ref_ctb());
        check({name, "_cto"}, int'(res[1]), ref_cto());
`ifdef PATTERN_CROSS_COUNT_EN
        check({name, "_cts"}, int'(res[2]), ref_cts());
`else
        check({name, "_cts_unwritten"}, int'(res[2]), 8'hEE);
`endif
        $display("run %s pat=%02h ctb=%0d cto=%0d cts=%0d ack_at=%0d writes=%0d",
                 name, pat_byte, res[0], res[1], res[2], ack_cycle, wr_count);
    endtask

    task automatic reset_mid_run();
        clear_results();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_ack", int'(ack), 0);
        check("mid_rst_wen", int'(mem_wen), 0);
        check("mid_rst_addr", int'(mem_addr), 0);
        check("mid_rst_wdata", int'(mem_wdata), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("mid_rst_no_writes", wr_count, 0);
        check("mid_rst_ack_low", int'(ack), 0);
        $display("reset at cycle 20 writes_after=%0d ack=%0d", wr_count, ack);
    endtask

    initial begin
        fill(8'h00);
        pat_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_wen", int'(mem_wen), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        @(negedge clk) reset_n = 1'b1;

        fill(8'h00); pat_byte = 8'h00; run("zeros", 1'b0);
        fill(8'h55); pat_byte = 8'hA8; run("alt", 1'b0);
        fill(8'h00); msg[0] = 8'h07; msg[1] = 8'hC0; pat_byte = 8'hF8; run("cross", 1'b0);
        fill(8'h00); pat_byte = 8'hF8; run("none", 1'b0);
        fill(8'hFF); run("ones", 1'b0);

        reset_mid_run();
        for (int k = 0; k < MSG_LEN; k++) msg[k] = 8'($urandom);
        pat_byte = 8'($urandom);
        run("after_rst", 1'b0);
        run("mid_start", 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < MSG_LEN; k++) msg[k] = 8'($urandom);
            pat_byte = 8'($urandom);
            run($sformatf("rand%0d", t), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
